// File: rtl/oled_spi_tx.sv
// oled_spi_tx: byte-wide, write-only 4-wire SPI master (mode 0) for the SSD1306.
// Takes one byte plus a D/C flag per spi_send request and pulses send_done when
// the byte has been shifted out MSB-first. All outputs are registered.
module oled_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_send,
    input  logic [7:0] spi_data,
    input  logic       dc,
    output logic       send_done,
    output logic       busy,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_dc,
    output logic       oled_cs_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t     r_state, w_state;
    logic [7:0] r_div, w_div;
    logic [2:0] r_bit, w_bit;
    // Bit 7 goes straight to oled_sdin at capture, so only bits 6..0 are held.
    logic [6:0] r_shift, w_shift;
    logic       w_done, w_busy, w_sclk, w_sdin, w_dc, w_cs_n;

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            send_done <= 1'b0;
            busy      <= 1'b0;
            oled_sclk <= 1'b0;
            oled_sdin <= 1'b0;
            oled_dc   <= 1'b0;
            oled_cs_n <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_div     <= w_div;
            r_bit     <= w_bit;
            r_shift   <= w_shift;
            send_done <= w_done;
            busy      <= w_busy;
            oled_sclk <= w_sclk;
            oled_sdin <= w_sdin;
            oled_dc   <= w_dc;
            oled_cs_n <= w_cs_n;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_done  = 1'b0;
        w_busy  = busy;
        w_sclk  = oled_sclk;
        w_sdin  = oled_sdin;
        w_dc    = oled_dc;
        w_cs_n  = oled_cs_n;

        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (spi_send) begin
                    w_state = S_SHIFT;
                    w_shift = spi_data[6:0];
                    w_sdin  = spi_data[7];
                    w_dc    = dc;
                    w_cs_n  = 1'b0;
                    w_busy  = 1'b1;
                    w_sclk  = 1'b0;
                    w_div   = '0;
                    w_bit   = '0;
                end
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div  = '0;
                    w_sclk = ~oled_sclk;
                    // Only the high->low toggle moves data or ends the byte.
                    if (oled_sclk) begin
                        if (r_bit != 3'd7) begin
                            w_sdin  = r_shift[6];
                            w_shift = {r_shift[5:0], 1'b0};
                            w_bit   = r_bit + 3'd1;
                        end else begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                            w_cs_n  = 1'b1;
                        end
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

endmodule
